// File: rtl/packet_controller_pkg.sv
// Types and helpers shared by the packet controller's slot allocator and its per-slot age timers.
package packet_controller_pkg;

    localparam int DEFAULT_NUM_ENTRIES  = 8;
    localparam int DEFAULT_HEADER_WIDTH = 32;
    localparam int DEFAULT_IDX_W        = $clog2(DEFAULT_NUM_ENTRIES);

    typedef logic [DEFAULT_IDX_W-1:0]        slot_index_t;
    typedef logic [DEFAULT_HEADER_WIDTH-1:0] header_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } slot_state_t;

    // Counter width that can hold the value timeout_cycles itself (the saturation point).
    function automatic int age_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/slot_age_timer.sv
// Per-slot saturating age counter; expired is high while the slot is busy and has reached the timeout.
module slot_age_timer
    import packet_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic nocclk,
    input  logic rst,
    input  logic busy,
    input  logic clear,
    output logic expired
);

    localparam int AGE_W = age_width(TIMEOUT_CYCLES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

    logic [AGE_W-1:0] age;

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (clear) begin
            age <= '0;
        end else if (busy && (age != AGE_MAX)) begin
            age <= age + 1'b1;
        end
    end

    assign expired = busy && (age == AGE_MAX);

endmodule

// File: rtl/packet_slot_allocator.sv
// Claims free slot indices for outbound headers, presents them to transmit, returns freed
// indices to the free-index buffer and flags slots that stay unacknowledged too long.
module packet_slot_allocator
    import packet_controller_pkg::*;
#(
    parameter int NUM_ENTRIES    = 8,
    parameter int HEADER_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = $clog2(NUM_ENTRIES)
) (
    input  logic                    nocclk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [HEADER_WIDTH-1:0] in_header,
    input  logic                    next_free_index_valid,
    input  logic [IDX_W-1:0]        next_free_index,
    output logic                    next_free_index_ready,
    output logic                    alloc_valid,
    input  logic                    alloc_ready,
    output logic [IDX_W-1:0]        alloc_index,
    output logic [HEADER_WIDTH-1:0] alloc_header,
    input  logic                    release_valid,
    input  logic [IDX_W-1:0]        release_index,
    output logic                    return_index_valid,
    output logic [IDX_W-1:0]        return_index,
    output logic                    timeout_valid,
    output logic [IDX_W-1:0]        timeout_index,
    input  logic                    timeout_ready,
    output logic                    release_error
);

    // All handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the return port is valid-only because the buffer always has room for a freed index.

    slot_state_t             state;
    logic [IDX_W-1:0]        alloc_idx_q;
    logic [NUM_ENTRIES-1:0]  busy;
    logic [NUM_ENTRIES-1:0]  expired;
    logic [NUM_ENTRIES-1:0]  age_clear;
    logic [HEADER_WIDTH-1:0] header_mem [NUM_ENTRIES];
    logic                    fire;
    logic                    rel_ok;
    logic                    rel_bad;
    logic                    to_take;

    assign fire    = in_valid && next_free_index_valid && ((state == EMPTY) || alloc_ready);
    assign rel_ok  = release_valid && busy[release_index];
    assign rel_bad = release_valid && !busy[release_index];
    assign to_take = timeout_valid && timeout_ready;

    assign in_ready              = fire;
    assign next_free_index_ready = fire;

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            alloc_idx_q <= '0;
        end else if (fire) begin
            state       <= HOLD;
            alloc_idx_q <= next_free_index;
        end else if (alloc_ready) begin
            state       <= EMPTY;
        end
    end

    // The held header is read from the slot table; it only changes when a new result is loaded.
    assign alloc_valid  = (state == HOLD);
    assign alloc_index  = alloc_idx_q;
    assign alloc_header = header_mem[alloc_idx_q];

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                header_mem[i] <= '0;
            end
        end else begin
            if (rel_ok) begin
                busy[release_index] <= 1'b0;
            end
            if (fire) begin
                busy[next_free_index]       <= 1'b1;
                header_mem[next_free_index] <= in_header;
            end
        end
    end

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            return_index_valid <= 1'b0;
            return_index       <= '0;
            release_error      <= 1'b0;
        end else begin
            return_index_valid <= rel_ok;
            if (rel_ok) begin
                return_index <= release_index;
            end
            release_error <= release_error | rel_bad;
        end
    end

    always_comb begin
        age_clear = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_clear[i] = (fire    && (next_free_index == IDX_W'(i))) ||
                           (rel_ok  && (release_index   == IDX_W'(i))) ||
                           (to_take && (timeout_index   == IDX_W'(i)));
        end
    end

    // Scan downward so the lowest expired slot wins.
    always_comb begin
        timeout_index = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (expired[i]) begin
                timeout_index = IDX_W'(i);
            end
        end
    end

    assign timeout_valid = |expired;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_timer
        slot_age_timer #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_timer (
            .nocclk (nocclk),
            .rst    (rst),
            .busy   (busy[g]),
            .clear  (age_clear[g]),
            .expired(expired[g])
        );
    end

endmodule

// File: tb/tb_packet_slot_allocator.sv
// Bench for packet_slot_allocator: table-driven vectors, hand-written multi-cycle sequences,
// and a randomized run against a slot-level reference model with a free-index queue.
module tb_packet_slot_allocator;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int T  = 16;
    localparam int IW = 3;

    logic          nocclk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_header;
    logic          next_free_index_valid;
    logic [IW-1:0] next_free_index;
    logic          next_free_index_ready;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] alloc_index;
    logic [W-1:0]  alloc_header;
    logic          release_valid;
    logic [IW-1:0] release_index;
    logic          return_index_valid;
    logic [IW-1:0] return_index;
    logic          timeout_valid;
    logic [IW-1:0] timeout_index;
    logic          timeout_ready;
    logic          release_error;

    packet_slot_allocator #(
        .NUM_ENTRIES   (N),
        .HEADER_WIDTH  (W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .nocclk               (nocclk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_header            (in_header),
        .next_free_index_valid(next_free_index_valid),
        .next_free_index      (next_free_index),
        .next_free_index_ready(next_free_index_ready),
        .alloc_valid          (alloc_valid),
        .alloc_ready          (alloc_ready),
        .alloc_index          (alloc_index),
        .alloc_header         (alloc_header),
        .release_valid        (release_valid),
        .release_index        (release_index),
        .return_index_valid   (return_index_valid),
        .return_index         (return_index),
        .timeout_valid        (timeout_valid),
        .timeout_index        (timeout_index),
        .timeout_ready        (timeout_ready),
        .release_error        (release_error)
    );

    // ---------------- clock / reset ----------------
    initial nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge nocclk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid              = 1'b0;
        in_header             = '0;
        next_free_index_valid = 1'b0;
        next_free_index       = '0;
        alloc_ready           = 1'b0;
        release_valid         = 1'b0;
        release_index         = '0;
        timeout_ready         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge nocclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_alloc(input logic [IW-1:0] idx, input logic [W-1:0] hdr, input logic ar);
        in_valid              = 1'b1;
        next_free_index_valid = 1'b1;
        next_free_index       = idx;
        in_header             = hdr;
        alloc_ready           = ar;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          iv;
        logic          fv;
        logic [IW-1:0] fi;
        logic          ar;
        logic          rv;
        logic [IW-1:0] ri;
        logic [W-1:0]  hdr;
        logic          e_ir;
        logic          e_av;
        logic [IW-1:0] e_ai;
        logic [W-1:0]  e_ah;
        logic          e_rv;
        logic [IW-1:0] e_ri;
        logic          e_err;
    } vec_t;

    vec_t vecs [11];

    // ---------------- scoreboard / reference model ----------------
    logic [IW+W-1:0] exp_q [$];
    int              free_q [$];
    bit              m_busy [N];
    int              m_age  [N];
    bit              m_ret_v;
    int              m_ret_i;
    bit              m_err;

    task automatic model_reset();
        exp_q.delete();
        free_q.delete();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_age[i]  = 0;
            free_q.push_back(i);
        end
        m_ret_v = 1'b0;
        m_ret_i = 0;
        m_err   = 1'b0;
    endtask

    initial begin
        logic [W-1:0] h1;
        logic [W-1:0] h2;
        rst = 1'b1;
        idle_inputs();

        //          iv fv fi ar rv ri hdr            ir av ai ah             rv ri err
        vecs[0]  = '{1, 1, 3, 1, 0, 0, 32'hA5A5_0003, 1, 1, 3, 32'hA5A5_0003, 0, 0, 0};
        vecs[1]  = '{0, 1, 4, 0, 0, 0, 32'h0,         0, 1, 3, 32'hA5A5_0003, 0, 0, 0};
        vecs[2]  = '{1, 1, 4, 0, 0, 0, 32'hB0B0_0004, 0, 1, 3, 32'hA5A5_0003, 0, 0, 0};
        vecs[3]  = '{1, 1, 4, 1, 0, 0, 32'hB0B0_0004, 1, 1, 4, 32'hB0B0_0004, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0};
        vecs[5]  = '{1, 0, 5, 1, 0, 0, 32'h1234_5678, 0, 0, 0, 32'h0,         0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 3, 32'h0,         0, 0, 0, 32'h0,         1, 3, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 3, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 4, 32'h0,         0, 0, 0, 32'h0,         1, 4, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1};

        // ---- reset values ----
        do_reset();
        check("rst_in_ready", in_ready, 0);
        check("rst_nfi_ready", next_free_index_ready, 0);
        check("rst_alloc_valid", alloc_valid, 0);
        check("rst_alloc_index", alloc_index, 0);
        check("rst_alloc_header", alloc_header, 0);
        check("rst_return_valid", return_index_valid, 0);
        check("rst_return_index", return_index, 0);
        check("rst_timeout_valid", timeout_valid, 0);
        check("rst_timeout_index", timeout_index, 0);
        check("rst_release_error", release_error, 0);

        // ---- table-driven vectors ----
        for (int v = 0; v < 11; v++) begin
            in_valid              = vecs[v].iv;
            next_free_index_valid = vecs[v].fv;
            next_free_index       = vecs[v].fi;
            alloc_ready           = vecs[v].ar;
            release_valid         = vecs[v].rv;
            release_index         = vecs[v].ri;
            in_header             = vecs[v].hdr;
            timeout_ready         = 1'b0;
            #1;
            check($sformatf("vec%0d_in_ready", v), in_ready, vecs[v].e_ir);
            check($sformatf("vec%0d_nfi_ready", v), next_free_index_ready, vecs[v].e_ir);
            tick();
            check($sformatf("vec%0d_alloc_valid", v), alloc_valid, vecs[v].e_av);
            if (vecs[v].e_av) begin
                check($sformatf("vec%0d_alloc_index", v), alloc_index, vecs[v].e_ai);
                check($sformatf("vec%0d_alloc_header", v), alloc_header, vecs[v].e_ah);
            end
            check($sformatf("vec%0d_return_valid", v), return_index_valid, vecs[v].e_rv);
            if (vecs[v].e_rv) begin
                check($sformatf("vec%0d_return_index", v), return_index, vecs[v].e_ri);
            end
            check($sformatf("vec%0d_release_error", v), release_error, vecs[v].e_err);
            check($sformatf("vec%0d_timeout_valid", v), timeout_valid, 0);
        end

        // ---- stall: one pop only while alloc_ready is low, outputs stable ----
        do_reset();
        h1 = 32'hC0DE_0001;
        h2 = 32'hC0DE_0002;
        drive_alloc(3'd1, h1, 1'b0);
        #1;
        check("stall_first_pop", in_ready, 1);
        tick();
        drive_alloc(3'd2, h2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("stall_no_pop%0d", k), next_free_index_ready, 0);
            tick();
            check($sformatf("stall_valid%0d", k), alloc_valid, 1);
            check($sformatf("stall_index%0d", k), alloc_index, 1);
            check($sformatf("stall_header%0d", k), alloc_header, h1);
        end
        alloc_ready = 1'b1;
        #1;
        check("stall_resume_pop", in_ready, 1);
        tick();
        check("stall_next_index", alloc_index, 2);
        check("stall_next_header", alloc_header, h2);
        idle_inputs();
        alloc_ready = 1'b1;
        tick();
        check("stall_drain", alloc_valid, 0);

        // ---- timeout ordering and re-expiry ----
        do_reset();
        drive_alloc(3'd2, 32'h0000_0022, 1'b1);
        tick();
        drive_alloc(3'd5, 32'h0000_0055, 1'b1);
        tick();
        idle_inputs();
        alloc_ready = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            check($sformatf("to_early_k%0d", k), timeout_valid, 0);
            tick();
        end
        check("to_first_valid", timeout_valid, 1);
        check("to_first_index", timeout_index, 2);
        tick();
        check("to_hold_valid", timeout_valid, 1);
        check("to_hold_index", timeout_index, 2);
        timeout_ready = 1'b1;
        tick();
        check("to_second_valid", timeout_valid, 1);
        check("to_second_index", timeout_index, 5);
        tick();
        for (int k = 20; k <= 34; k++) begin
            check($sformatf("to_rearm_k%0d", k), timeout_valid, 0);
            tick();
        end
        check("to_reexpire_valid", timeout_valid, 1);
        check("to_reexpire_index", timeout_index, 2);

        // ---- reset during HOLD with a return pulse in flight ----
        do_reset();
        drive_alloc(3'd6, 32'hDEAD_0006, 1'b0);
        tick();
        idle_inputs();
        release_valid = 1'b1;
        release_index = 3'd6;
        tick();
        idle_inputs();
        check("mid_pre_return", return_index_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_alloc_valid", alloc_valid, 0);
        check("mid_alloc_index", alloc_index, 0);
        check("mid_alloc_header", alloc_header, 0);
        check("mid_return_valid", return_index_valid, 0);
        check("mid_return_index", return_index, 0);
        check("mid_timeout_valid", timeout_valid, 0);
        check("mid_in_ready", in_ready, 0);
        check("mid_release_error", release_error, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_return", return_index_valid, 0);
        check("post_rst_alloc", alloc_valid, 0);
        release_valid = 1'b1;
        release_index = 3'd6;
        tick();
        release_valid = 1'b0;
        check("post_rst_slot_free", return_index_valid, 0);
        check("post_rst_error", release_error, 1);

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit e_fire;
            bit e_tv;
            int e_ti;
            bit rel_ok;
            int bl [$];

            check("rnd_alloc_valid", alloc_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("rnd_alloc_index", alloc_index, exp_q[0][IW+W-1:W]);
                check("rnd_alloc_header", alloc_header, exp_q[0][W-1:0]);
            end
            check("rnd_return_valid", return_index_valid, m_ret_v);
            if (m_ret_v) check("rnd_return_index", return_index, m_ret_i);
            check("rnd_release_error", release_error, m_err);

            in_valid              = ($urandom_range(0, 3) != 0);
            in_header             = $urandom;
            next_free_index_valid = (free_q.size() > 0) && ($urandom_range(0, 4) != 0);
            next_free_index       = (free_q.size() > 0) ? IW'(free_q[0]) : IW'($urandom);
            alloc_ready           = ($urandom_range(0, 2) != 0);
            timeout_ready         = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) if (m_busy[i]) bl.push_back(i);
            release_valid = 1'b0;
            release_index = IW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                release_valid = 1'b1;
            end else if (bl.size() > 0 && $urandom_range(0, 39) == 0) begin
                release_valid = 1'b1;
                release_index = IW'(bl[$urandom_range(0, bl.size() - 1)]);
            end

            e_fire = in_valid && next_free_index_valid && ((exp_q.size() == 0) || alloc_ready);
            e_tv   = 1'b0;
            e_ti   = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_busy[i] && m_age[i] == T) begin
                    e_tv = 1'b1;
                    e_ti = i;
                end
            end
            #1;
            check("rnd_in_ready", in_ready, e_fire);
            check("rnd_nfi_ready", next_free_index_ready, e_fire);
            check("rnd_timeout_valid", timeout_valid, e_tv);
            if (e_tv) check("rnd_timeout_index", timeout_index, e_ti);

            tick();

            rel_ok = release_valid && m_busy[release_index];
            if (release_valid && !m_busy[release_index]) m_err = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && m_age[i] < T) m_age[i]++;
            end
            if (e_tv && timeout_ready) m_age[e_ti] = 0;
            if (rel_ok) begin
                m_busy[release_index] = 1'b0;
                m_age[release_index]  = 0;
                free_q.push_back(int'(release_index));
            end
            if (exp_q.size() != 0 && alloc_ready) void'(exp_q.pop_front());
            if (e_fire) begin
                m_busy[next_free_index] = 1'b1;
                m_age[next_free_index]  = 0;
                void'(free_q.pop_front());
                exp_q.push_back({next_free_index, in_header});
            end
            m_ret_v = rel_ok;
            if (rel_ok) m_ret_i = int'(release_index);
        end

        // ---- final report ----
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
